// File: rtl/input_ctrl.sv
// Board input front end: synchronizes keys and switches, debounces keys into one-clock
// press strobes, and holds a captured switch value until the consumer acknowledges it.
module input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_WIDTH      = 16,
    parameter int SW_WIDTH        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            btn,
    input  logic [8:0]            sw,
    input  logic                  in_ack,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_valid,
    output logic                  overrun,
    output logic [2:0]            btn_pulse,
    output logic [7:0]            press_cnt,
    output logic                  state_dbg
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, FULL} state_e;

    state_e               state;
    logic [2:0]           btn_s1, btn_s2;
    logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
    logic [1:0]           settle;
    logic [2:0]           stable;
    logic [2:0]           armed;
    logic [CNT_W-1:0]     db_cnt [3];
    logic                 unused_sw;

    assign unused_sw = ^sw[8:SW_WIDTH];
    assign state_dbg = (state == FULL);

    // settle[1] marks that btn_s2 now carries real post-reset samples rather than reset values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= '1;
            btn_s2 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
            settle <= '0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            sw_s1  <= sw[SW_WIDTH-1:0];
            sw_s2  <= sw_s1;
            settle <= {settle[0], 1'b1};
        end
    end

    // A key is armed only once seen released after reset, so a key held through reset never strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable    <= '1;
            armed     <= '0;
            btn_pulse <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                armed[i]     <= armed[i] | (settle[1] & btn_s2[i]);
                btn_pulse[i] <= armed[i] & stable[i] & ~btn_s2[i] & (db_cnt[i] == CNT_LAST);
                if (btn_s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    stable[i] <= btn_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Handshake: in_valid stays high from capture until the cycle after in_ack is seen;
    // in_ack while in_valid is low has no effect. Clear outranks load and in_ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_valid  <= 1'b0;
            in_data   <= '0;
            overrun   <= 1'b0;
            press_cnt <= '0;
        end else begin
            if (btn_pulse[2]) press_cnt <= press_cnt + 8'd1;
            if (btn_pulse[1]) begin
                state    <= IDLE;
                in_valid <= 1'b0;
                in_data  <= '0;
                overrun  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (btn_pulse[0]) begin
                            state    <= FULL;
                            in_valid <= 1'b1;
                            in_data  <= DATA_WIDTH'(sw_s2);
                        end
                    end
                    FULL: begin
                        if (btn_pulse[0] && in_ack) begin
                            in_data <= DATA_WIDTH'(sw_s2);
                        end else if (btn_pulse[0]) begin
                            overrun <= 1'b1;
                        end else if (in_ack) begin
                            state    <= IDLE;
                            in_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        in_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/input_ctrl.md
INPUT_CTRL -- requirements
Module: input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive clocks a synchronized button level must hold before it is accepted.
REQ-002 Parameter DATA_WIDTH, default 16: width of in_data.
REQ-003 Parameter SW_WIDTH, default 4: number of low switch bits captured.
REQ-004 clk  input  1  single clock for the whole block; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn  input  3  raw board keys, active-low (0 = pressed), asynchronous to clk; btn[0]=load, btn[1]=clear, btn[2]=count.
REQ-007 sw  input  9  raw slide switches, asynchronous to clk.
REQ-008 in_ack  input  1  consumer acknowledge, active-high, one clock wide.
REQ-009 in_data  output  DATA_WIDTH  captured switch value, zero-extended.
REQ-010 in_valid  output  1  high while in_data holds an unconsumed value.
REQ-011 overrun  output  1  sticky: a load was refused while in_valid was high.
REQ-012 btn_pulse  output  3  one-clock press strobe per key, active-high.
REQ-013 press_cnt  output  8  number of accepted presses of btn[2].

Function
REQ-014 Every btn bit and sw[SW_WIDTH-1:0] SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Each key SHALL have its own debounce counter and stable level; the counter increments while the synchronized level differs from the stable level and clears to 0 on any cycle where they agree.
REQ-016 The stable level SHALL flip, and the counter clear, on the edge at which the counter would reach DEBOUNCE_CYCLES.
REQ-017 btn_pulse[i] SHALL be high for exactly one clock, the cycle after stable[i] goes released→pressed; release SHALL produce no pulse.
REQ-018 Latency from a clean raw press to btn_pulse high SHALL be DEBOUNCE_CYCLES+2 clocks; glitches shorter than DEBOUNCE_CYCLES clocks SHALL produce no pulse.
REQ-019 Control FSM states: IDLE (in_valid=0) and FULL (in_valid=1).
REQ-020 IDLE + load pulse: in_data <= zero-extended synchronized sw[SW_WIDTH-1:0]; next state FULL.
REQ-021 FULL + in_ack (no load): in_valid drops the next cycle; next state IDLE; in_data retained.
REQ-022 FULL + load pulse without in_ack: data not overwritten, overrun <= 1, state stays FULL.
REQ-023 FULL + in_ack and load pulse in the same cycle: new data captured, state stays FULL, overrun unchanged.
REQ-024 IDLE + in_ack: ignored.
REQ-025 Clear pulse in any state: in_data <= 0, overrun <= 0, next state IDLE; clear has priority over load and in_ack in the same cycle.
REQ-026 Count pulse: press_cnt increments by 1, wrapping 255→0; independent of FSM and unaffected by clear.
REQ-027 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-028 rst_n low SHALL asynchronously force: synchronizers and stable levels to released (1), debounce counters 0, btn_pulse 0, state IDLE, in_valid 0, in_data 0, overrun 0, press_cnt 0.
REQ-029 Reset asserted mid-debounce or in FULL SHALL discard all pending state; no pulse SHALL be emitted for a key held through reset deassertion until it is released and pressed again.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset with btn=3'b111, sw=9'h005 -> all outputs 0, in_valid 0, press_cnt 0.
REQ-031 sw[3:0]=4'hA, btn[0] held low 10 clocks -> btn_pulse[0] high exactly one clock 6 clocks after the press; in_data=16'h000A, in_valid=1 the following cycle.
REQ-032 btn[0] low for 3 clocks then high -> no btn_pulse, in_valid unchanged.
REQ-033 With in_valid=1, sw=4'h3, second load press, no ack -> in_data stays 16'h000A, overrun=1; then in_ack pulse -> in_valid=0; clear press -> overrun=0, in_data=0.
REQ-034 Clear and load pulses in the same cycle while IDLE -> state IDLE, in_valid 0, in_data 0.
REQ-035 256 clean btn[2] presses -> press_cnt returns to 0; a 257th press -> press_cnt=1.
